// File: rtl/micro_op_queue_pkg.sv
// Shared micro-op field widths and the queue entry layout, reused by the
// micro-op generator and the micro-op queue.
package micro_op_queue_pkg;

    localparam int MICRO_W    = 8;
    localparam int REG_ADDR_W = 5;
    localparam int IMM_W      = 32;
    localparam int BIT_MODE_W = 2;
    localparam int ADDR_W     = 32;

    typedef struct packed {
        logic [MICRO_W-1:0]    opcode;
        logic [REG_ADDR_W-1:0] reg_addr_d;
        logic [REG_ADDR_W-1:0] reg_addr_s;
        logic [REG_ADDR_W-1:0] reg_addr_t;
        logic [IMM_W-1:0]      immediate;
        logic [BIT_MODE_W-1:0] bit_mode;
        logic                  efl_mode;
        logic [ADDR_W-1:0]     pc;
    } micro_op_entry_t;

endpackage

// File: rtl/micro_op_queue.sv
// Micro-op FIFO between the micro-op generator and the decode phase.
// Head is presented from registered state only; an empty queue shows a NOP bubble.
module micro_op_queue
    import micro_op_queue_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  logic [MICRO_W-1:0]    enq_opcode,
    input  logic [REG_ADDR_W-1:0] enq_reg_addr_d,
    input  logic [REG_ADDR_W-1:0] enq_reg_addr_s,
    input  logic [REG_ADDR_W-1:0] enq_reg_addr_t,
    input  logic [IMM_W-1:0]      enq_immediate,
    input  logic [BIT_MODE_W-1:0] enq_bit_mode,
    input  logic                  enq_efl_mode,
    input  logic [ADDR_W-1:0]     enq_pc,

    output logic                  deq_valid,
    output logic [MICRO_W-1:0]    deq_opcode_head,
    output logic [REG_ADDR_W-1:0] deq_reg_addr_d_head,
    output logic [REG_ADDR_W-1:0] deq_reg_addr_s_head,
    output logic [REG_ADDR_W-1:0] deq_reg_addr_t_head,
    output logic [IMM_W-1:0]      deq_immediate_head,
    output logic [BIT_MODE_W-1:0] deq_bit_mode_head,
    output logic                  deq_efl_mode_head,
    output logic [ADDR_W-1:0]     deq_pc_head,

    input  logic                  stall,
    input  logic                  flush,
    output logic [PTR_W:0]        count
);

    micro_op_entry_t mem [DEPTH];
    micro_op_entry_t enq_entry;
    micro_op_entry_t head;

    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic             enq_fire;
    logic             pop_fire;

    assign enq_ready = (count != (PTR_W+1)'(DEPTH));
    assign deq_valid = (count != '0);

    assign enq_fire = enq_valid & enq_ready & ~flush;
    assign pop_fire = deq_valid & ~stall & ~flush;

    assign enq_entry = '{
        opcode:     enq_opcode,
        reg_addr_d: enq_reg_addr_d,
        reg_addr_s: enq_reg_addr_s,
        reg_addr_t: enq_reg_addr_t,
        immediate:  enq_immediate,
        bit_mode:   enq_bit_mode,
        efl_mode:   enq_efl_mode,
        pc:         enq_pc
    };

    // NOTE: storage has no reset; count gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[wp] <= enq_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (enq_fire) begin
                wp <= wp + PTR_W'(1);
            end
            if (pop_fire) begin
                rp <= rp + PTR_W'(1);
            end
            unique case ({enq_fire, pop_fire})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Asynchronous read: the decode phase samples the head on the same edge it pops.
    assign head = deq_valid ? mem[rp] : '0;

    assign deq_opcode_head     = head.opcode;
    assign deq_reg_addr_d_head = head.reg_addr_d;
    assign deq_reg_addr_s_head = head.reg_addr_s;
    assign deq_reg_addr_t_head = head.reg_addr_t;
    assign deq_immediate_head  = head.immediate;
    assign deq_bit_mode_head   = head.bit_mode;
    assign deq_efl_mode_head   = head.efl_mode;
    assign deq_pc_head         = head.pc;

endmodule

// File: doc/micro_op_queue.md
# micro_op_queue

Synchronous FIFO of decoded micro-ops between the x86 instruction decoder (micro-op generator) and the decode phase. Enqueue side accepts one micro-op per cycle from the generator. Dequeue side presents the head entry on the `deq_*_head` bus the decode phase samples; the head is popped on every cycle the decode phase is not stalled. Pipeline flush empties the queue.

## Interface
- `DEPTH`, 8: number of entries; power of two, ≥2.
- `PTR_W`, `$clog2(DEPTH)`: read/write pointer width (derived; not overridden).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `enq_valid`  in  1  generator offers a micro-op this cycle.
- `enq_ready`  out  1  queue can accept; equals `count < DEPTH`.
- `enq_opcode`  in  `` `MICRO_W ``  micro-op opcode.
- `enq_reg_addr_d` / `_s` / `_t`  in  `` `REG_ADDR_W `` each  register addresses.
- `enq_immediate`  in  `` `IMM_W ``  immediate.
- `enq_bit_mode`  in  `` `BIT_MODE_W ``  operand size mode.
- `enq_efl_mode`  in  1  EFLAGS update enable.
- `enq_pc`  in  `` `ADDR_W ``  PC of the originating x86 instruction.
- `deq_valid`  out  1  head holds a real entry.
- `deq_opcode_head`, `deq_reg_addr_{d,s,t}_head`, `deq_immediate_head`, `deq_bit_mode_head`, `deq_efl_mode_head`, `deq_pc_head`  out  same widths as the matching `enq_*` field  head entry fields.
- `stall`  in  1  decode phase stalled; head not consumed.
- `flush`  in  1  discard all entries.
- `count`  out  `PTR_W+1`  current occupancy, 0..`DEPTH`.

## Operation
- Storage: `DEPTH` entries holding all `enq_*` fields; write pointer `wp`, read pointer `rp`, occupancy `count`.
- Enqueue fires when `enq_valid & enq_ready & ~flush`. The entry is written at `wp`, then `wp <= wp+1` (wraps mod `DEPTH`).
- Pop fires when `deq_valid & ~stall & ~flush`. Then `rp <= rp+1` (wraps mod `DEPTH`).
- `count` update:
  - +1 for an enqueue alone.
  - −1 for a pop alone.
  - Unchanged when both fire or neither fires.
- `deq_valid = (count != 0)`.
- Head outputs:
  - When `deq_valid`, they are `entry[rp]`.
  - When empty, every head field is 0 (opcode 0 = NOP bubble).
- Full: `enq_ready = 0`. A same-cycle pop does not raise `enq_ready`; no pass-through.
- Empty: no fall-through. An enqueue into an empty queue becomes visible at the head the next cycle.
- Simultaneous enqueue and pop at `count == 1`: the old head pops and the new entry becomes head next cycle; `count` stays 1.
- Flush has priority over enqueue and pop:
  - `wp`, `rp` and `count` go to 0.
  - Any same-cycle enqueue is dropped.
  - Head outputs read 0 from the next cycle.
- `stall` with `flush` asserted: flush wins.
- Wrap-around: pointers are `PTR_W` bits and roll over naturally; full/empty is determined only by `count`.

## Timing
- Reset (`rst` high at an edge): `wp = rp = count = 0`, so `deq_valid = 0`, `enq_ready = 1`, all head fields 0. Storage contents are not reset.
- Reset mid-operation discards all entries, same as flush. Reset overrides flush, enqueue and pop.
- `enq_ready`, `deq_valid`, `count` and the head fields are functions of registered state only. No combinational path from any `enq_*`, `stall` or `flush` input to any output.
- Enqueue-to-head latency: 1 cycle when the queue is empty.
- Throughput: one enqueue and one pop per cycle sustained.
- The decode phase registers the head on the same edge the pop takes effect. Head data must therefore be stable from the start of the cycle.

## Structure
- Field widths come from `common_params.h`; no new macros are needed there.
- A shared package defines `micro_op_entry_t`: a packed struct of opcode, reg_addr_d/s/t, immediate, bit_mode, efl_mode and pc. The generator and later queue variants reuse it.
- No sub-module: pointer/count logic and the storage array are inline. Storage may infer distributed RAM as long as reads stay asynchronous.

## Test plan
- **Reset then idle:** hold `rst` 2 cycles, then release → `count = 0`, `deq_valid = 0`, `enq_ready = 1`, `deq_opcode_head = 0`.
- **Single entry:** enqueue opcode `0x12`, pc `0x100` with `stall = 0` → next cycle `deq_valid = 1` with head opcode `0x12` / pc `0x100`; the cycle after, `deq_valid = 0`.
- **Fill to full:** with `stall = 1`, enqueue 8 entries pc `0..7` → `count = 8`, `enq_ready = 0`. A 9th `enq_valid` is ignored. Releasing `stall` yields pc `0..7` in order over 8 cycles.
- **Wrap-around:** interleave 20 enqueues and pops with random stall → FIFO order preserved across pointer wrap; `count` never exceeds 8.
- **Flush with simultaneous enqueue:** 5 entries queued, `flush = 1` and `enq_valid = 1` in the same cycle → next cycle `count = 0`, `deq_valid = 0`, head fields 0, enqueued entry lost.
- **Equal enqueue and pop at `count = 1`:** enqueue pc `0x20` while pc `0x10` pops → next cycle `count = 1`, head pc `0x20`.
